instr_fetch_unit: RTL and testbench

- IF-stage initiator that drives fetch addresses into the synchronous instruction memory and collects the returned words.
- The memory returns the word one clock after the address is presented.
- Returned PC/instruction pairs are buffered in a 2-entry FIFO and presented to decode with a valid/stall handshake.
- Handles taken-branch redirects and flushes; faults sticky on a misaligned target.

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// IF-stage fetch unit: issues sequential addresses to a 1-cycle synchronous
// instruction memory and buffers returned PC/instruction pairs in a 2-entry FIFO.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fetch_err
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    logic        fetch_err_r;
    logic [31:0] pc_r;
    logic        inflight_valid_r;
    logic [31:0] inflight_pc_r;
    logic [1:0]  count_r;
    logic        valid_r;
    logic [31:0] head_pc_r;
    logic [31:0] head_instr_r;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_instr_r;

    logic        pop_s;
    logic        push_s;
    logic        run_s;
    logic        redirect_s;
    logic        misalign_s;
    logic        issue_s;
    logic [2:0]  occupancy_s;

    // Handshake decode and fetch credit: buffered + in-flight after this pop must leave room.
    always_comb begin
        pop_s       = valid_r & ~if_stall;
        push_s      = inflight_valid_r;
        run_s       = (state_r == ST_RUN);
        redirect_s  = run_s & br_taken;
        misalign_s  = (br_target[1:0] != 2'b00);
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_valid_r} - {2'b00, pop_s};
        issue_s     = run_s & ~br_taken & (occupancy_s < 3'd2);
    end

    // Fetch FSM, in-flight tracking and FIFO storage with registered decode outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_RUN;
            fetch_err_r      <= 1'b0;
            pc_r             <= RESET_PC;
            inflight_valid_r <= 1'b0;
            inflight_pc_r    <= 32'h0000_0000;
            count_r          <= 2'd0;
            valid_r          <= 1'b0;
            head_pc_r        <= 32'h0000_0000;
            head_instr_r     <= NOP_INSTR;
            tail_pc_r        <= 32'h0000_0000;
            tail_instr_r     <= 32'h0000_0000;
        end else begin
            inflight_pc_r <= pc_r;
            if (redirect_s) begin
                // Redirect outranks pop/push/issue; the in-flight word is dropped.
                inflight_valid_r <= 1'b0;
                count_r          <= 2'd0;
                valid_r          <= 1'b0;
                head_instr_r     <= NOP_INSTR;
                if (misalign_s) begin
                    state_r     <= ST_HALT;
                    fetch_err_r <= 1'b1;
                end else begin
                    pc_r <= br_target;
                end
            end else begin
                inflight_valid_r <= issue_s;
                if (issue_s) begin
                    pc_r <= pc_r + 32'd4;
                end
                case ({push_s, pop_s})
                    2'b10: begin
                        if (count_r == 2'd0) begin
                            head_pc_r    <= inflight_pc_r;
                            head_instr_r <= imem_instr;
                            valid_r      <= 1'b1;
                        end else begin
                            tail_pc_r    <= inflight_pc_r;
                            tail_instr_r <= imem_instr;
                        end
                        count_r <= count_r + 2'd1;
                    end
                    2'b01: begin
                        if (count_r == 2'd2) begin
                            head_pc_r    <= tail_pc_r;
                            head_instr_r <= tail_instr_r;
                        end else begin
                            head_instr_r <= NOP_INSTR;
                            valid_r      <= 1'b0;
                        end
                        count_r <= count_r - 2'd1;
                    end
                    2'b11: begin
                        if (count_r == 2'd2) begin
                            head_pc_r    <= tail_pc_r;
                            head_instr_r <= tail_instr_r;
                            tail_pc_r    <= inflight_pc_r;
                            tail_instr_r <= imem_instr;
                        end else begin
                            head_pc_r    <= inflight_pc_r;
                            head_instr_r <= imem_instr;
                        end
                    end
                    default: begin
                        count_r <= count_r;
                    end
                endcase
            end
        end
    end

    assign imem_pc   = pc_r;
    assign if_valid  = valid_r;
    assign if_pc     = head_pc_r;
    assign if_instr  = head_instr_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an instruction-stream model predicts the
// decode-side outputs every cycle, and literal checks pin the key scenarios.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr = 32'h0000_0000;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_stall   (if_stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, mem[k] = 0x100 + k
    logic [31:0] mem [0:255];
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h100 + 32'(k);
    end
    always @(posedge clk) imem_instr <= mem[imem_pc[9:2]];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h100 + {24'd0, pc[9:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model: after a (re)start the head shows up two cycles later and then
    // stays valid; it advances by one word per accepted instruction.
    int          m_since = 0;
    logic        m_halt  = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_last  = 32'h0;
    logic        m_valid;
    assign m_valid = !m_halt && (m_since >= 2);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_since <= 0;
            m_halt  <= 1'b0;
            m_err   <= 1'b0;
            m_pc    <= 32'h0;
            m_last  <= 32'h0;
        end else begin
            if (m_valid) m_last <= m_pc;
            if (m_since < 1000) m_since <= m_since + 1;
            if (!m_halt && br_taken) begin
                if (br_target[1:0] != 2'b00) begin
                    m_halt <= 1'b1;
                    m_err  <= 1'b1;
                end else begin
                    m_pc    <= br_target;
                    m_since <= 0;
                end
            end else if (m_valid && !if_stall) begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("if_pc", if_pc, m_pc);
            check("if_instr", if_instr, instr_of(m_pc));
        end else begin
            check("if_pc_hold", if_pc, m_last);
            check("if_instr_nop", if_instr, NOP);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_imem_pc"}, imem_pc, 32'h0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_pc"}, if_pc, 32'h0);
        check({tag, "_instr"}, if_instr, NOP);
        check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, ins);
    endtask

    initial begin
        rst = 1'b0; if_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        @(negedge clk);                                    // t=10
        check_reset_vals("rst0");
        rst = 1'b1;
        @(negedge clk);                                    // t=20
        check("lat_c1_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk); expect_head("first", 32'h0, 32'h100);   // t=30
        @(negedge clk); expect_head("seq1", 32'h4, 32'h101);    // t=40
        @(negedge clk); expect_head("seq2", 32'h8, 32'h102);    // t=50
        if_stall = 1'b1;
        repeat (5) @(negedge clk);                         // t=100
        expect_head("stall_hold", 32'h8, 32'h102);
        check("stall_imem_pc", imem_pc, 32'h10);
        if_stall = 1'b0;
        @(negedge clk); expect_head("rel1", 32'hC, 32'h103);    // t=110
        @(negedge clk); expect_head("rel2", 32'h10, 32'h104);   // t=120
        if_stall = 1'b1;
        @(negedge clk);                                    // t=130, two buffered
        expect_head("buf2", 32'h10, 32'h104);
        if_stall = 1'b0; br_taken = 1'b1; br_target = 32'h40;
        @(negedge clk); br_taken = 1'b0;                   // t=140
        check("br_gap1", {31'd0, if_valid}, 32'd0);
        @(negedge clk);                                    // t=150
        check("br_gap2", {31'd0, if_valid}, 32'd0);
        @(negedge clk); expect_head("br_tgt", 32'h40, 32'h110); // t=160
        if_stall = 1'b1; br_taken = 1'b1; br_target = 32'h80;
        @(negedge clk); br_taken = 1'b0; if_stall = 1'b0;  // t=170
        check("brst_gap1", {31'd0, if_valid}, 32'd0);
        @(negedge clk);                                    // t=180
        check("brst_gap2", {31'd0, if_valid}, 32'd0);
        @(negedge clk); expect_head("brst_tgt", 32'h80, 32'h120); // t=190
        br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
        @(negedge clk); br_taken = 1'b0;                   // t=200
        repeat (2) @(negedge clk);                         // t=220
        expect_head("wrap0", 32'hFFFF_FFF8, 32'h1FE);
        @(negedge clk); expect_head("wrap1", 32'hFFFF_FFFC, 32'h1FF); // t=230
        @(negedge clk); expect_head("wrap2", 32'h0, 32'h100);          // t=240
        br_taken = 1'b1; br_target = 32'h42;
        @(negedge clk); br_taken = 1'b0;                   // t=250
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        check("mis_valid", {31'd0, if_valid}, 32'd0);
        repeat (2) @(negedge clk);                         // t=270
        br_taken = 1'b1; br_target = 32'h0;
        @(negedge clk); br_taken = 1'b0;                   // t=280
        repeat (3) @(negedge clk);                         // t=310
        check("halt_err", {31'd0, fetch_err}, 32'd1);
        check("halt_valid", {31'd0, if_valid}, 32'd0);
        #2 rst = 1'b0;                                     // t=312
        #1 check_reset_vals("rst_halt");
        @(negedge clk); rst = 1'b1;                        // t=320
        repeat (2) @(negedge clk);                         // t=340
        expect_head("restart0", 32'h0, 32'h100);
        @(negedge clk); expect_head("restart1", 32'h4, 32'h101);  // t=350
        @(negedge clk); expect_head("restart2", 32'h8, 32'h102);  // t=360
        #3 rst = 1'b0;                                     // t=363
        #1 check_reset_vals("rst_async");
        @(negedge clk); rst = 1'b1;                        // t=370
        repeat (2) @(negedge clk);                         // t=390
        expect_head("resume0", 32'h0, 32'h100);
        @(negedge clk); expect_head("resume1", 32'h4, 32'h101);   // t=400
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
